shift_add_mac: RTL
==================

Name: shift_add_mac

Overview:
- Sequential unsigned shift-and-add multiply-accumulate: computes product = multiplicand * multiplier + addend.
- Processes one multiplier bit per ADD/SHIFT state pair; latency is fixed.
- Serves as the inverse of the team's sequential divider: quotient * divisor + remainder reconstructs the dividend. Also used standalone as a small area multiplier.
- Start/busy/done handshake; the result is held until the next operation.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request a new operation; sampled only in IDLE
- multiplicand  input  WIDTH  operand M, captured on accepted start
- multiplier  input  WIDTH  operand Q, captured on accepted start
- addend  input  WIDTH  operand R, captured on accepted start
- busy  output  1  high in ADD and SHIFT states
- done  output  1  single-cycle pulse; product is valid from this cycle onward
- product  output  2*WIDTH  registered result, held until the next DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal accumulator, carry and counter are cleared.
- Internal registers:
  - acc: 2*WIDTH bits, split into upper half U and lower half L.
  - cy: 1 bit, carry above U.
  - m_reg: WIDTH bits.
  - cnt: $clog2(WIDTH+1) bits.
- IDLE:
  - If start=1: U<=addend, L<=multiplier, cy<=0, m_reg<=multiplicand, cnt<=0; go to ADD.
  - Otherwise stay in IDLE.
- ADD: if L[0]=1, {cy,U} <= U + m_reg, a (WIDTH+1)-bit add. Otherwise hold. Go to SHIFT.
- SHIFT:
  - {cy,U,L} <= {1'b0,cy,U,L} >> 1, i.e. a logical right shift of the full 2*WIDTH+1 bits.
  - cnt <= cnt+1.
  - If cnt==WIDTH-1 (last iteration), go to DONE; otherwise go to ADD.
- DONE:
  - product <= acc, written on entry to DONE (at the SHIFT->DONE edge).
  - done=1 for exactly this one cycle; next state is IDLE.
- Arithmetic:
  - Initialising U with addend yields acc = M*Q + R after WIDTH iterations.
  - Max (2^W-1)^2 + (2^W-1) < 2^(2W), so there is no overflow and cy is 0 at completion.
  - The ADD sum needs WIDTH+1 bits; the carry must not be dropped.
- Latency:
  - If start is sampled at edge E, product updates and done rises after edge E+2*WIDTH.
  - For WIDTH=4 that is 8 cycles.
  - Latency is data-independent: no early exit when multiplier=0.
- Handshake:
  - start is ignored in ADD, SHIFT and DONE. There is no queueing.
  - Back-to-back: start may be asserted in the first IDLE cycle after DONE. Minimum issue interval is 2*WIDTH+2 cycles.
  - Operands need to be stable only in the accepting cycle.
- Outputs:
  - product changes only on entry to DONE or on reset. Intermediate acc values are never visible.
  - busy and done are decoded from registered state. Both are 0 in IDLE.
- Reset mid-operation: immediate abort; all outputs are as after reset, and no done pulse is issued.
- Encodings 4..7 of the 2-bit-plus state register are illegal. If a 3-bit encoding is used, they must recover to IDLE.

Decomposition:
- Shared package (the arithmetic package already used by the divider):
  - state encoding localparams IDLE=0, ADD=1, SHIFT=2, DONE=3;
  - WIDTH default constant;
  - function mac_ref(M,Q,R), a reference model for benches.
- Single module; no sub-module is natural. The conditional (WIDTH+1)-bit adder stays inline.

Test Plan:
- WIDTH=4; M=13, Q=11, R=7, start pulse -> done after 8 cycles; product=150 (0x96); busy high for 8 cycles, then 0.
- Max operands M=15, Q=15, R=15 -> product=240 (0xF0). Checks carry retention in ADD.
- Zero cases: M=9, Q=0, R=9 -> 9; then M=0, Q=7, R=0 -> 0; each takes exactly 8 cycles.
- Divider round trip: dividend 13 / divisor 4 -> Q=3, R=1; feed M=4, Q=3, R=1 -> product=13.
- Start held high continuously with changing operands -> only operands present in the IDLE cycle are used; done pulses every 10 cycles.
- Reset pulled low 3 cycles into M=5, Q=3, R=0 -> busy=0, done=0, product=0, no done pulse. Then release and run M=6, Q=9, R=4 -> 58 (0x3A).

Source files
------------

// File: rtl/shift_add_mac_pkg.sv
// rtl/shift_add_mac_pkg.sv - shared arithmetic constants, state encoding and reference model
package shift_add_mac_pkg;

    localparam int MAC_WIDTH = 4;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ADD   = 3'd1;
    localparam logic [STATE_W-1:0] SHIFT = 3'd2;
    localparam logic [STATE_W-1:0] DONE  = 3'd3;

    // Golden M*Q+R at the default width, for benches and quick checks.
    function automatic logic [2*MAC_WIDTH-1:0] mac_ref(
        input logic [MAC_WIDTH-1:0] m,
        input logic [MAC_WIDTH-1:0] q,
        input logic [MAC_WIDTH-1:0] r
    );
        return (2*MAC_WIDTH)'(m) * (2*MAC_WIDTH)'(q) + (2*MAC_WIDTH)'(r);
    endfunction

endpackage

// File: rtl/shift_add_mac_if.sv
// rtl/shift_add_mac_if.sv - start/busy/done operand and result bundle
interface shift_add_mac_if
    import shift_add_mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     addend;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output busy, done, product
    );

endinterface

// File: rtl/shift_add_mac.sv
// rtl/shift_add_mac.sv - sequential unsigned shift-and-add multiply-accumulate
module shift_add_mac
    import shift_add_mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    shift_add_mac_if.slave  bus
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next_state;

    logic                r_cy;
    logic [WIDTH-1:0]    r_u;
    logic [WIDTH-1:0]    r_l;
    logic [WIDTH-1:0]    r_m;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_product;

    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH:0]    w_shifted;
    logic                w_last;
    logic                w_load;
    logic                w_add;
    logic                w_shift;
    logic                w_busy;
    logic                w_done;

    // Carry out of the add must survive into cy, so the sum is one bit wider.
    assign w_sum     = {1'b0, r_u} + {1'b0, r_m};
    // Logical right shift of {cy,U,L}; a zero enters above the carry.
    assign w_shifted = {1'b0, r_cy, r_u, r_l[WIDTH-1:1]};
    assign w_last    = (r_cnt == LAST_CNT);

    // State register; async abort returns straight to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed ADD/SHIFT pairs, no early exit; illegal codes recover to IDLE.
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = bus.start ? ADD : IDLE;
            ADD:     w_next_state = SHIFT;
            SHIFT:   w_next_state = w_last ? DONE : ADD;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output and datapath strobes decoded from the registered state.
    always_comb begin
        w_load  = 1'b0;
        w_add   = 1'b0;
        w_shift = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE:  w_load = bus.start;
            ADD: begin
                w_add  = r_l[0];
                w_busy = 1'b1;
            end
            SHIFT: begin
                w_shift = 1'b1;
                w_busy  = 1'b1;
            end
            DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Accumulator, carry, multiplicand and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cy  <= 1'b0;
            r_u   <= '0;
            r_l   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_cy  <= 1'b0;
            r_u   <= bus.addend;
            r_l   <= bus.multiplier;
            r_m   <= bus.multiplicand;
            r_cnt <= '0;
        end else if (w_add) begin
            r_cy  <= w_sum[WIDTH];
            r_u   <= w_sum[WIDTH-1:0];
        end else if (w_shift) begin
            r_cy  <= w_shifted[2*WIDTH];
            r_u   <= w_shifted[2*WIDTH-1:WIDTH];
            r_l   <= w_shifted[WIDTH-1:0];
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Result is captured only on the final shift, so partial sums never show.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_product <= '0;
        end else if (w_shift && w_last) begin
            r_product <= w_shifted[2*WIDTH-1:0];
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;

endmodule
